// File: rtl/dispatch_ctrl.sv
// Single-entry dispatch buffer: takes decoded instructions and allocates ROB entries.
// It resolves operands from RF rename status and the CDB, then issues to the RS or the LSB.
module dispatch_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int REG_WIDTH  = 5,
   parameter int ROB_WIDTH  = 3
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  flush_in,
   // decoder
   input  logic                  DCDP_en,
   input  logic [ADDR_WIDTH-1:0] DCDP_pc,
   input  logic [6:0]            DCDP_opcode,
   input  logic [REG_WIDTH-1:0]  DCDP_rs1,
   input  logic [REG_WIDTH-1:0]  DCDP_rs2,
   input  logic [REG_WIDTH-1:0]  DCDP_rd,
   input  logic [19:0]           DCDP_imm,
   input  logic                  DCDP_predict_result,
   output logic                  DPIF_stall,
   // back-end capacity
   input  logic                  ROB_full,
   input  logic                  RS_full,
   input  logic                  LSB_full,
   input  logic [ROB_WIDTH-1:0]  ROB_tail,
   // register file query
   output logic [REG_WIDTH-1:0]  DPRF_rs1,
   output logic [REG_WIDTH-1:0]  DPRF_rs2,
   input  logic [31:0]           RF_val1,
   input  logic [31:0]           RF_val2,
   input  logic                  RF_dep1,
   input  logic                  RF_dep2,
   input  logic [ROB_WIDTH-1:0]  RF_tag1,
   input  logic [ROB_WIDTH-1:0]  RF_tag2,
   // common data bus
   input  logic                  CDB_en,
   input  logic [ROB_WIDTH-1:0]  CDB_rob_id,
   input  logic [31:0]           CDB_value,
   // dispatch outputs
   output logic                  DPROB_en,
   output logic                  DPRS_en,
   output logic                  DPLSB_en,
   output logic                  DPRF_en,
   output logic [6:0]            DP_opcode,
   output logic [ADDR_WIDTH-1:0] DP_pc,
   output logic [19:0]           DP_imm,
   output logic [REG_WIDTH-1:0]  DP_rd,
   output logic                  DP_predict_result,
   output logic [31:0]           DP_val1,
   output logic [31:0]           DP_val2,
   output logic                  DP_dep1,
   output logic                  DP_dep2,
   output logic [ROB_WIDTH-1:0]  DP_tag1,
   output logic [ROB_WIDTH-1:0]  DP_tag2,
   output logic [ROB_WIDTH-1:0]  DP_rob_id
);

   typedef enum logic {EMPTY, FULL} state_t;

   typedef struct packed {
      logic                 dep;
      logic [ROB_WIDTH-1:0] tag;
      logic [31:0]          val;
   } opnd_t;

   state_t                 state;
   logic [6:0]             op_q;
   logic [ADDR_WIDTH-1:0]  pc_q;
   logic [19:0]            imm_q;
   logic [REG_WIDTH-1:0]   rs1_q, rs2_q, rd_q;
   logic                   pred_q;

   logic  full, is_lsb, fire_raw, fire, accept, writes_rd, use1, use2;
   opnd_t op1, op2;

   // A matching CDB broadcast beats the RF's pending status in the same cycle.
   function automatic opnd_t resolve(input logic used, input logic [REG_WIDTH-1:0] r,
                                     input logic [31:0] rv, input logic dep,
                                     input logic [ROB_WIDTH-1:0] tag, input logic cdb_en,
                                     input logic [ROB_WIDTH-1:0] cdb_id,
                                     input logic [31:0] cdb_val);
      opnd_t o;
      o = '0;
      if (used && r != '0) begin
         if (dep && cdb_en && cdb_id == tag) o.val = cdb_val;
         else if (dep) begin
            o.dep = 1'b1;
            o.tag = tag;
         end else o.val = rv;
      end
      return o;
   endfunction

   always_comb begin
      full      = (state == FULL);
      is_lsb    = (op_q >= 7'd11) && (op_q <= 7'd18);
      fire_raw  = full && !ROB_full && (is_lsb ? !LSB_full : !RS_full);
      fire      = fire_raw && !flush_in;
      accept    = DCDP_en && (DCDP_opcode != 7'd0) && (!full || fire);
      writes_rd = !((op_q >= 7'd5) && (op_q <= 7'd10)) && !((op_q >= 7'd16) && (op_q <= 7'd18));
      use1      = (op_q == 7'd4) || ((op_q >= 7'd5) && (op_q <= 7'd37));
      use2      = ((op_q >= 7'd5) && (op_q <= 7'd10)) || ((op_q >= 7'd16) && (op_q <= 7'd18)) ||
                  ((op_q >= 7'd28) && (op_q <= 7'd37));
      op1       = resolve(use1, rs1_q, RF_val1, RF_dep1, RF_tag1, CDB_en, CDB_rob_id, CDB_value);
      op2       = resolve(use2, rs2_q, RF_val2, RF_dep2, RF_tag2, CDB_en, CDB_rob_id, CDB_value);
   end

   assign DPIF_stall        = full && !fire_raw;
   assign DPROB_en          = fire;
   assign DPRS_en           = fire && !is_lsb;
   assign DPLSB_en          = fire && is_lsb;
   assign DPRF_en           = fire && writes_rd && (rd_q != '0);
   assign DPRF_rs1          = rs1_q;
   assign DPRF_rs2          = rs2_q;
   assign DP_opcode         = op_q;
   assign DP_pc             = pc_q;
   assign DP_imm            = imm_q;
   assign DP_rd             = rd_q;
   assign DP_predict_result = pred_q;
   assign DP_rob_id         = ROB_tail;
   assign DP_val1           = op1.val;
   assign DP_dep1           = op1.dep;
   assign DP_tag1           = op1.tag;
   assign DP_val2           = op2.val;
   assign DP_dep2           = op2.dep;
   assign DP_tag2           = op2.tag;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state  <= EMPTY;
         op_q   <= '0;
         pc_q   <= '0;
         imm_q  <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         rd_q   <= '0;
         pred_q <= 1'b0;
      end else if (flush_in) begin
         state <= EMPTY;
      end else if (accept) begin
         state  <= FULL;
         op_q   <= DCDP_opcode;
         pc_q   <= DCDP_pc;
         imm_q  <= DCDP_imm;
         rs1_q  <= DCDP_rs1;
         rs2_q  <= DCDP_rs2;
         rd_q   <= DCDP_rd;
         pred_q <= DCDP_predict_result;
      end else if (fire) begin
         state <= EMPTY;
      end
   end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: inputs change on the falling edge, outputs checked 1ns later.
module tb_dispatch_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in, flush_in;
   logic        DCDP_en, DCDP_predict_result;
   logic [31:0] DCDP_pc;
   logic [6:0]  DCDP_opcode;
   logic [4:0]  DCDP_rs1, DCDP_rs2, DCDP_rd;
   logic [19:0] DCDP_imm;
   logic        DPIF_stall, ROB_full, RS_full, LSB_full;
   logic [2:0]  ROB_tail;
   logic [4:0]  DPRF_rs1, DPRF_rs2;
   logic [31:0] RF_val1, RF_val2;
   logic        RF_dep1, RF_dep2;
   logic [2:0]  RF_tag1, RF_tag2;
   logic        CDB_en;
   logic [2:0]  CDB_rob_id;
   logic [31:0] CDB_value;
   logic        DPROB_en, DPRS_en, DPLSB_en, DPRF_en;
   logic [6:0]  DP_opcode;
   logic [31:0] DP_pc;
   logic [19:0] DP_imm;
   logic [4:0]  DP_rd;
   logic        DP_predict_result;
   logic [31:0] DP_val1, DP_val2;
   logic        DP_dep1, DP_dep2;
   logic [2:0]  DP_tag1, DP_tag2, DP_rob_id;

   int vec = 0;
   int err = 0;

   // {DPROB_en, DPRS_en, DPLSB_en, DPRF_en, DPIF_stall}
   wire [4:0] ctl = {DPROB_en, DPRS_en, DPLSB_en, DPRF_en, DPIF_stall};

   always #5 clk_in = ~clk_in;

   dispatch_ctrl #(.ADDR_WIDTH(32), .REG_WIDTH(5), .ROB_WIDTH(3)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
      .DCDP_en(DCDP_en), .DCDP_pc(DCDP_pc), .DCDP_opcode(DCDP_opcode),
      .DCDP_rs1(DCDP_rs1), .DCDP_rs2(DCDP_rs2), .DCDP_rd(DCDP_rd),
      .DCDP_imm(DCDP_imm), .DCDP_predict_result(DCDP_predict_result),
      .DPIF_stall(DPIF_stall), .ROB_full(ROB_full), .RS_full(RS_full),
      .LSB_full(LSB_full), .ROB_tail(ROB_tail),
      .DPRF_rs1(DPRF_rs1), .DPRF_rs2(DPRF_rs2),
      .RF_val1(RF_val1), .RF_val2(RF_val2), .RF_dep1(RF_dep1), .RF_dep2(RF_dep2),
      .RF_tag1(RF_tag1), .RF_tag2(RF_tag2),
      .CDB_en(CDB_en), .CDB_rob_id(CDB_rob_id), .CDB_value(CDB_value),
      .DPROB_en(DPROB_en), .DPRS_en(DPRS_en), .DPLSB_en(DPLSB_en), .DPRF_en(DPRF_en),
      .DP_opcode(DP_opcode), .DP_pc(DP_pc), .DP_imm(DP_imm), .DP_rd(DP_rd),
      .DP_predict_result(DP_predict_result),
      .DP_val1(DP_val1), .DP_val2(DP_val2), .DP_dep1(DP_dep1), .DP_dep2(DP_dep2),
      .DP_tag1(DP_tag1), .DP_tag2(DP_tag2), .DP_rob_id(DP_rob_id)
   );

   task automatic idle();
      DCDP_en = 0; DCDP_pc = 0; DCDP_opcode = 0; DCDP_rs1 = 0; DCDP_rs2 = 0;
      DCDP_rd = 0; DCDP_imm = 0; DCDP_predict_result = 0;
      ROB_full = 0; RS_full = 0; LSB_full = 0; ROB_tail = 0; flush_in = 0;
      RF_val1 = 0; RF_val2 = 0; RF_dep1 = 0; RF_dep2 = 0; RF_tag1 = 0; RF_tag2 = 0;
      CDB_en = 0; CDB_rob_id = 0; CDB_value = 0;
   endtask

   task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] pc, input logic [19:0] imm,
                        input logic pr);
      DCDP_en = 1; DCDP_opcode = op; DCDP_rd = rd; DCDP_rs1 = rs1; DCDP_rs2 = rs2;
      DCDP_pc = pc; DCDP_imm = imm; DCDP_predict_result = pr;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk_in);
      @(negedge clk_in); rst_in = 0; #1;
      vec++; if (ctl !== 5'b00000) begin err++; $display("FAIL reset_ctl got %b exp 00000", ctl); end
      vec++; if ({DP_opcode, DP_pc, DP_imm, DP_rd} !== 64'd0) begin
         err++; $display("FAIL reset_fields got op=%0d pc=%h imm=%h rd=%0d exp all 0",
                         DP_opcode, DP_pc, DP_imm, DP_rd); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk_in); idle(); RF_val1 = 32'h11; RF_val2 = 32'h22;
      drive(7'd19, 5'd1, 5'd2, 5'd3, 32'h100, 20'h5, 0); #1;
      vec++; if (ctl !== 5'b00000) begin err++; $display("FAIL b2b_c1_ctl got %b exp 00000", ctl); end
      @(negedge clk_in); drive(7'd28, 5'd3, 5'd1, 5'd2, 32'h104, 20'h0, 0); #1;
      vec++; if (ctl !== 5'b11010) begin err++; $display("FAIL b2b_c2_ctl got %b exp 11010", ctl); end
      vec++; if ({DP_opcode, DP_rob_id, DP_pc} !== {7'd19, 3'd0, 32'h100}) begin
         err++; $display("FAIL b2b_c2_fields got op=%0d rob=%0d pc=%h exp 19 0 100",
                         DP_opcode, DP_rob_id, DP_pc); end
      vec++; if ({DP_val1, DP_val2, DPRF_rs1} !== {32'h11, 32'h0, 5'd2}) begin
         err++; $display("FAIL b2b_c2_opnd got v1=%h v2=%h rs1=%0d exp 11 0 2",
                         DP_val1, DP_val2, DPRF_rs1); end
      @(negedge clk_in); DCDP_en = 0; ROB_tail = 3'd1; #1;
      vec++; if (ctl !== 5'b11010) begin err++; $display("FAIL b2b_c3_ctl got %b exp 11010", ctl); end
      vec++; if ({DP_opcode, DP_rob_id, DP_val1, DP_val2} !== {7'd28, 3'd1, 32'h11, 32'h22}) begin
         err++; $display("FAIL b2b_c3_fields got op=%0d rob=%0d v1=%h v2=%h exp 28 1 11 22",
                         DP_opcode, DP_rob_id, DP_val1, DP_val2); end
      @(negedge clk_in); #1;
      vec++; if (ctl !== 5'b00000) begin err++; $display("FAIL b2b_c4_ctl got %b exp 00000", ctl); end
   endtask

   task automatic test_struct_stall();
      @(negedge clk_in); idle(); LSB_full = 1; RS_full = 1;
      drive(7'd13, 5'd4, 5'd5, 5'd0, 32'h200, 20'h8, 0); #1;
      vec++; if (ctl !== 5'b00000) begin err++; $display("FAIL stall_load_ctl got %b exp 00000", ctl); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in); #1;
         vec++; if ({ctl, DP_opcode} !== {5'b00001, 7'd13}) begin
            err++; $display("FAIL stall_hold%0d got ctl=%b op=%0d exp 00001 13", i, ctl, DP_opcode); end
      end
      @(negedge clk_in); LSB_full = 0; DCDP_en = 0; #1;
      vec++; if ({ctl, DP_rd} !== {5'b10110, 5'd4}) begin
         err++; $display("FAIL stall_release got ctl=%b rd=%0d exp 10110 4", ctl, DP_rd); end
      @(negedge clk_in); #1;
      vec++; if (ctl !== 5'b00000) begin err++; $display("FAIL stall_after got %b exp 00000", ctl); end
   endtask

   task automatic test_forwarding();
      @(negedge clk_in); idle(); drive(7'd28, 5'd6, 5'd7, 5'd8, 32'h300, 20'h0, 0); #1;
      @(negedge clk_in); DCDP_en = 0; RS_full = 1; RF_dep1 = 1; RF_tag1 = 3'd5;
      RF_val1 = 32'hdead; RF_val2 = 32'h99; CDB_en = 1; CDB_rob_id = 3'd5; CDB_value = 32'h1234; #1;
      vec++; if ({DP_dep1, DP_val1} !== {1'b0, 32'h1234}) begin
         err++; $display("FAIL fwd_hit got dep=%b val=%h exp 0 1234", DP_dep1, DP_val1); end
      vec++; if ({DP_dep2, DP_val2, DPRF_rs1, DPRF_rs2, ctl} !== {1'b0, 32'h99, 5'd7, 5'd8, 5'b00001}) begin
         err++; $display("FAIL fwd_rs2 got dep=%b val=%h rs1=%0d rs2=%0d ctl=%b exp 0 99 7 8 00001",
                         DP_dep2, DP_val2, DPRF_rs1, DPRF_rs2, ctl); end
      @(negedge clk_in); CDB_rob_id = 3'd4; #1;
      vec++; if ({DP_dep1, DP_tag1} !== {1'b1, 3'd5}) begin
         err++; $display("FAIL fwd_miss got dep=%b tag=%0d exp 1 5", DP_dep1, DP_tag1); end
      @(negedge clk_in); CDB_en = 0; CDB_rob_id = 3'd5; #1;
      vec++; if ({DP_dep1, DP_tag1} !== {1'b1, 3'd5}) begin
         err++; $display("FAIL fwd_cdb_off got dep=%b tag=%0d exp 1 5", DP_dep1, DP_tag1); end
      @(negedge clk_in); RS_full = 0; RF_dep1 = 0; #1;
      vec++; if ({ctl, DP_dep1, DP_val1} !== {5'b11010, 1'b0, 32'hdead}) begin
         err++; $display("FAIL fwd_issue got ctl=%b dep=%b val=%h exp 11010 0 dead", ctl, DP_dep1, DP_val1); end
      @(negedge clk_in); #1;
      vec++; if (ctl !== 5'b00000) begin err++; $display("FAIL fwd_after got %b exp 00000", ctl); end
   endtask

   task automatic test_no_writeback();
      @(negedge clk_in); idle(); RF_dep1 = 1; RF_tag1 = 3'd2; RF_val1 = 32'h55;
      drive(7'd5, 5'd3, 5'd1, 5'd2, 32'h400, 20'h10, 1); #1;
      @(negedge clk_in); drive(7'd19, 5'd0, 5'd0, 5'd0, 32'h404, 20'h1, 0); #1;
      vec++; if ({ctl, DP_predict_result, DP_dep1, DP_tag1} !== {5'b11000, 1'b1, 1'b1, 3'd2}) begin
         err++; $display("FAIL nowb_beq got ctl=%b pr=%b dep=%b tag=%0d exp 11000 1 1 2",
                         ctl, DP_predict_result, DP_dep1, DP_tag1); end
      @(negedge clk_in); drive(7'd18, 5'd5, 5'd0, 5'd9, 32'h408, 20'h4, 0); #1;
      vec++; if ({ctl, DP_dep1, DP_val1} !== {5'b11000, 1'b0, 32'h0}) begin
         err++; $display("FAIL nowb_addi_x0 got ctl=%b dep=%b val=%h exp 11000 0 0", ctl, DP_dep1, DP_val1); end
      @(negedge clk_in); DCDP_en = 0; #1;
      vec++; if (ctl !== 5'b10100) begin err++; $display("FAIL nowb_sw got %b exp 10100", ctl); end
      @(negedge clk_in); #1;
      vec++; if (ctl !== 5'b00000) begin err++; $display("FAIL nowb_after got %b exp 00000", ctl); end
   endtask

   task automatic test_invalid_op();
      @(negedge clk_in); idle(); drive(7'd0, 5'd1, 5'd1, 5'd1, 32'h500, 20'h0, 0); #1;
      vec++; if (ctl !== 5'b00000) begin err++; $display("FAIL inval_c1 got %b exp 00000", ctl); end
      @(negedge clk_in); DCDP_en = 0; #1;
      vec++; if (ctl !== 5'b00000) begin err++; $display("FAIL inval_c2 got %b exp 00000", ctl); end
   endtask

   task automatic test_flush();
      @(negedge clk_in); idle(); drive(7'd19, 5'd1, 5'd2, 5'd0, 32'h600, 20'h0, 0); #1;
      @(negedge clk_in); DCDP_en = 0; ROB_full = 1; #1;
      vec++; if (ctl !== 5'b00001) begin err++; $display("FAIL flush_hold got %b exp 00001", ctl); end
      @(negedge clk_in); flush_in = 1; drive(7'd28, 5'd3, 5'd1, 5'd2, 32'h604, 20'h0, 0); #1;
      vec++; if (ctl[4:1] !== 4'b0000) begin err++; $display("FAIL flush_cycle_en got %b exp 0000", ctl[4:1]); end
      @(negedge clk_in); flush_in = 0; DCDP_en = 0; ROB_full = 0; #1;
      vec++; if (ctl !== 5'b00000) begin err++; $display("FAIL flush_after got %b exp 00000", ctl); end
      // flush against an instruction that would otherwise fire
      @(negedge clk_in); drive(7'd19, 5'd1, 5'd2, 5'd0, 32'h608, 20'h0, 0); #1;
      @(negedge clk_in); DCDP_en = 0; flush_in = 1; #1;
      vec++; if (ctl[4:1] !== 4'b0000) begin err++; $display("FAIL flush_prio_en got %b exp 0000", ctl[4:1]); end
      @(negedge clk_in); flush_in = 0; #1;
      vec++; if (ctl !== 5'b00000) begin err++; $display("FAIL flush_prio_after got %b exp 00000", ctl); end
   endtask

   task automatic test_reset_mid_hold();
      @(negedge clk_in); idle(); drive(7'd16, 5'd0, 5'd1, 5'd2, 32'h700, 20'h0, 0); #1;
      @(negedge clk_in); DCDP_en = 0; ROB_full = 1; #1;
      vec++; if (ctl !== 5'b00001) begin err++; $display("FAIL rst_hold got %b exp 00001", ctl); end
      @(negedge clk_in); rst_in = 1; #1;
      @(negedge clk_in); rst_in = 0; ROB_full = 0; #1;
      vec++; if ({ctl, DP_opcode} !== {5'b00000, 7'd0}) begin
         err++; $display("FAIL rst_after got ctl=%b op=%0d exp 00000 0", ctl, DP_opcode); end
      @(negedge clk_in); drive(7'd19, 5'd2, 5'd1, 5'd0, 32'h800, 20'h0, 0); #1;
      @(negedge clk_in); DCDP_en = 0; ROB_tail = 3'd3; #1;
      vec++; if ({ctl, DP_rob_id, DP_pc} !== {5'b11010, 3'd3, 32'h800}) begin
         err++; $display("FAIL rst_first got ctl=%b rob=%0d pc=%h exp 11010 3 800", ctl, DP_rob_id, DP_pc); end
      @(negedge clk_in); #1;
      vec++; if (ctl !== 5'b00000) begin err++; $display("FAIL rst_first_after got %b exp 00000", ctl); end
   endtask

   initial begin
      idle();
      rst_in = 1;
      test_reset();
      test_back_to_back();
      test_struct_stall();
      test_forwarding();
      test_no_writeback();
      test_invalid_op();
      test_flush();
      test_reset_mid_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- Sequences decoded instructions from the decoder into the back end.
- Holds one decoded instruction in a single-entry buffer and allocates a ROB entry for it.
- Resolves source operands through the register-file rename status and same-cycle CDB forwarding.
- Routes the instruction to the ALU reservation station (RS) or the load/store buffer (LSB), and back-pressures the instruction fetcher when the buffer cannot drain.

Parameters:
- ADDR_WIDTH, 32, PC width.
- REG_WIDTH, 5, architectural register index width.
- ROB_WIDTH, 3, ROB index width (8 entries).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- DCDP_en  input  1  decoded instruction valid.
- DCDP_pc  input  ADDR_WIDTH  instruction PC.
- DCDP_opcode  input  7  internal op code (1=lui … 37=and; 0=invalid).
- DCDP_rs1, DCDP_rs2, DCDP_rd  input  REG_WIDTH each  register indices.
- DCDP_imm  input  20  decoded immediate.
- DCDP_predict_result  input  1  1 = predicted taken.
- DPIF_stall  output  1  fetcher must hold its current instruction.
- ROB_full, RS_full, LSB_full  input  1 each  target cannot accept this cycle.
- ROB_tail  input  ROB_WIDTH  index the next allocation receives.
- DPRF_rs1, DPRF_rs2  output  REG_WIDTH  combinational register-file query.
- RF_val1, RF_val2  input  32  register values.
- RF_dep1, RF_dep2  input  1  register awaits a ROB result.
- RF_tag1, RF_tag2  input  ROB_WIDTH  producing ROB index.
- CDB_en  input  1  result broadcast valid.
- CDB_rob_id  input  ROB_WIDTH  broadcasting entry.
- CDB_value  input  32  broadcast value.
- DPROB_en  output  1  allocate ROB entry.
- DPRS_en  output  1  issue to RS.
- DPLSB_en  output  1  issue to LSB.
- DPRF_en  output  1  mark rd as renamed to ROB_tail.
- DP_opcode, DP_pc, DP_imm, DP_rd, DP_predict_result  output  7/ADDR_WIDTH/20/REG_WIDTH/1  buffered fields, shared by ROB/RS/LSB.
- DP_val1, DP_val2  output  32  operand values.
- DP_dep1, DP_dep2  output  1  operand still pending.
- DP_tag1, DP_tag2  output  ROB_WIDTH  pending producer index.
- DP_rob_id  output  ROB_WIDTH  allocated ROB index (= ROB_tail).
- flush_in  input  1  mispredict flush from ROB.

Behaviour:
- States:
  - EMPTY: buffer invalid.
  - FULL: buffer holds one instruction.
- Class of the buffered op:
  - LSB ops: opcodes 11–18.
  - RS ops: all other nonzero opcodes.
  - Opcode 0 is never accepted: it is dropped silently and asserts no stall.
- fire = FULL && !ROB_full && (LSB op ? !LSB_full : !RS_full). Combinational.
- Outputs in the fire cycle:
  - DPROB_en=1.
  - Exactly one of DPRS_en / DPLSB_en = 1.
  - DP_rob_id = ROB_tail.
- DPRF_en=1 only when fire && rd≠0 && op writes rd. Branches (5–10) and stores (16–18) never write rd.
- Accept: DCDP_en && opcode≠0 && (EMPTY || fire) → latch all fields; state becomes FULL at the next edge.
- If fire and no accept in the same cycle → EMPTY at the next edge.
- DPIF_stall = FULL && !fire. While stalled the decoder holds its inputs stable; the block ignores DCDP_en.
- Latency: an instruction accepted at edge N dispatches at the earliest in the cycle after edge N, i.e. one cycle of buffering. Sustained throughput is 1 per cycle.
- Operand resolution is combinational from the buffered rs1/rs2, evaluated every cycle, so it is never stale while holding.
  - rs1 is used by jalr, branches, loads, stores and ALU ops 19–37.
  - rs2 is used by branches, stores and ALU-reg ops 28–37.
  - Unused operand: dep=0, val=0, tag=0.
  - Register 0: dep=0, val=0.
  - If RF_dep=1 && CDB_en && CDB_rob_id==RF_tag → val=CDB_value, dep=0.
  - Else if RF_dep=1 → dep=1, tag=RF_tag.
  - Otherwise → val=RF_val, dep=0.
- Flush:
  - flush_in=1 → state EMPTY at the next edge; any same-cycle accept is discarded.
  - All *_en outputs are forced 0 in the flush cycle; flush takes priority over fire.
- Reset:
  - rst_in=1 at an edge → EMPTY, all buffered fields 0.
  - All *_en outputs = 0 and DPIF_stall=0 from the following cycle.
  - Reset mid-hold discards the held instruction.
- No enable output may be high while in EMPTY.

Test Plan:
- Back-to-back: addi (19) accepted at cycle 1, add (28) at cycle 2, no full signals → DPRS_en high in cycles 2 and 3. DP_rob_id follows ROB_tail 0 then 1. DPIF_stall is never high.
- Structural stall: buffered lw (13) with LSB_full=1 for 3 cycles → DPIF_stall=1 for 3 cycles, no enables. On the 4th cycle DPLSB_en=1, DPROB_en=1 and DPRF_en=1.
- Forwarding: buffered add with RF_dep1=1, RF_tag1=5, CDB_en=1, CDB_rob_id=5, CDB_value=0x1234 → DP_dep1=0, DP_val1=0x1234. With CDB_rob_id=4 instead → DP_dep1=1, DP_tag1=5.
- No-writeback: buffered beq (5) with rd=3, and a separate buffered addi with rd=0 → DPRF_en=0 for both while DPRS_en=1. sw (18) → DPLSB_en=1, DPRF_en=0.
- Flush: FULL and stalled by ROB_full=1, with flush_in=1 and DCDP_en=1 in the same cycle → next cycle EMPTY, no enables, DPIF_stall=0. The new instruction is not latched.
- Reset: rst_in=1 while holding sb with RS/LSB free → enables and DPIF_stall are 0 from the following cycle. The first instruction after reset dispatches normally.
